// File: rtl/operand_sync_fifo.sv
// operand_sync_fifo: brings an asynchronous operand pair and a bouncing
// load strobe into the clk domain. It qualifies each load pulse as a single
// capture and queues the captured operands in a 4-entry FIFO for the adder.
module operand_sync_fifo #(
   parameter int SYNC_STAGES   = 2,
   parameter int STABLE_CYCLES = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] a_in,
   input  logic [7:0] b_in,
   input  logic       load,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [7:0] out_a,
   output logic [7:0] out_b,
   output logic [2:0] count,
   output logic       overflow
);

   localparam logic [3:0] STABLE_MAX  = 4'(STABLE_CYCLES);
   localparam logic [3:0] STABLE_LAST = 4'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0]       load_chain;
   logic [SYNC_STAGES-1:0][7:0]  a_chain;
   logic [SYNC_STAGES-1:0][7:0]  b_chain;
   logic                         sync_load;
   logic [7:0]                   a_sync;
   logic [7:0]                   b_sync;

   logic [3:0]  stable_cnt;
   logic        captured;
   logic        capture;

   logic [15:0] mem [4];
   logic [1:0]  wr_ptr;
   logic [1:0]  rd_ptr;
   logic        full;
   logic        push;
   logic        pop;
   logic [15:0] head;

   assign sync_load = load_chain[SYNC_STAGES-1];
   assign a_sync    = a_chain[SYNC_STAGES-1];
   assign b_sync    = b_chain[SYNC_STAGES-1];

   // Synchroniser chains: load and both operands travel through equal-depth
   // chains so the operands arrive aligned with the strobe that captures them.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         load_chain <= '0;
         a_chain    <= '0;
         b_chain    <= '0;
      end else begin
         load_chain <= {load_chain[SYNC_STAGES-2:0], load};
         a_chain    <= {a_chain[SYNC_STAGES-2:0], a_in};
         b_chain    <= {b_chain[SYNC_STAGES-2:0], b_in};
      end
   end

   // Debounce: count consecutive enabled high cycles. After a capture, the
   // captured flag blocks further captures until the strobe drops again.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable_cnt <= '0;
         captured   <= 1'b0;
      end else begin
         if (!sync_load || !ena)
            stable_cnt <= '0;
         else if (stable_cnt != STABLE_MAX)
            stable_cnt <= stable_cnt + 4'd1;

         if (!sync_load)
            captured <= 1'b0;
         else if (capture)
            captured <= 1'b1;
      end
   end

   assign capture = sync_load && ena && !captured && (stable_cnt == STABLE_LAST);

   // Queue handshake: a full FIFO still accepts a capture when the head
   // leaves on the same edge, because the freed slot is the one being written.
   assign full      = (count == 3'd4);
   assign out_valid = (count != 3'd0);
   assign pop       = out_valid && out_ready;
   assign push      = capture && (!full || pop);
   assign head      = mem[rd_ptr];
   assign out_a     = head[15:8];
   assign out_b     = head[7:0];

   // FIFO storage, pointers, occupancy and the sticky drop flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 4; i++)
            mem[i] <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= {a_sync, b_sync};
            wr_ptr      <= wr_ptr + 2'd1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 2'd1;
         case ({push, pop})
            2'b10:   count <= count + 3'd1;
            2'b01:   count <= count - 3'd1;
            default: count <= count;
         endcase
         if (capture && full && !pop)
            overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_operand_sync_fifo.sv
// tb_operand_sync_fifo: directed stimulus with a scoreboard queue of expected
// operand pairs, drained by a monitor whenever the DUT hands off its head entry.
module tb_operand_sync_fifo;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       ena;
   logic [7:0] a_in;
   logic [7:0] b_in;
   logic       load;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_a;
   logic [7:0] out_b;
   logic [2:0] count;
   logic       overflow;

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q [$];

   operand_sync_fifo #(.SYNC_STAGES(2), .STABLE_CYCLES(3)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .a_in      (a_in),
      .b_in      (b_in),
      .load      (load),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_a     (out_a),
      .out_b     (out_b),
      .count     (count),
      .overflow  (overflow)
   );

   // Free-running 10-unit clock.
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [15:0] actual, input logic [15:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   // Monitor: at the falling edge, a visible handshake means the head leaves
   // on the next rising edge, so compare it against the oldest expectation.
   always @(negedge clk) begin
      if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_pop: got %h%h expected no entry", out_a, out_b);
         end else begin
            check_output("pop_data", {out_a, out_b}, exp_q.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      check_output("rst_count", 16'(count), 16'd0);
      check_output("rst_valid", 16'(out_valid), 16'd0);
      check_output("rst_overflow", 16'(overflow), 16'd0);
      check_output("rst_data", {out_a, out_b}, 16'h0000);
      exp_q.delete();
      #4 rst_n = 1'b1;
   endtask

   task automatic apply_stimulus(input logic [7:0] a, input logic [7:0] b, input int len);
      a_in = a;
      b_in = b;
      load = 1'b1;
      repeat (len) step();
      load = 1'b0;
      repeat (6) step();
   endtask

   task automatic drain();
      out_ready = 1'b1;
      repeat (8) step();
      out_ready = 1'b0;
      check_output("drain_count", 16'(count), 16'd0);
   endtask

   initial begin
      rst_n = 1'b0; ena = 1'b1; a_in = '0; b_in = '0; load = 1'b0; out_ready = 1'b0;
      #2;
      check_output("init_count", 16'(count), 16'd0);
      check_output("init_valid", 16'(out_valid), 16'd0);
      check_output("init_data", {out_a, out_b}, 16'h0000);
      #5 rst_n = 1'b1;
      step();

      // Held load: capture on edge 4, no repeat while load stays high.
      a_in = 8'h12; b_in = 8'h34; load = 1'b1;
      exp_q.push_back(16'h1234);
      repeat (4) step();
      check_output("latency_not_yet", 16'(out_valid), 16'd0);
      step();
      check_output("latency_valid", 16'(out_valid), 16'd1);
      check_output("latency_data", {out_a, out_b}, 16'h1234);
      check_output("latency_count", 16'(count), 16'd1);
      repeat (10) step();
      check_output("held_single", 16'(count), 16'd1);
      check_output("hold_data", {out_a, out_b}, 16'h1234);
      load = 1'b0;
      repeat (4) step();
      drain();

      // Short pulses rejected, long pulse accepted once.
      apply_stimulus(8'hAA, 8'hBB, 1);
      apply_stimulus(8'hAA, 8'hBB, 2);
      check_output("short_count", 16'(count), 16'd0);
      check_output("short_valid", 16'(out_valid), 16'd0);
      exp_q.push_back(16'h5678);
      apply_stimulus(8'h56, 8'h78, 5);
      check_output("long_count", 16'(count), 16'd1);
      drain();

      // Fill past capacity: fifth capture dropped, overflow sticks.
      for (int i = 1; i <= 5; i++) begin
         if (i <= 4) exp_q.push_back({8'(i), 8'(i + 16)});
         apply_stimulus(8'(i), 8'(i + 16), 5);
      end
      check_output("full_count", 16'(count), 16'd4);
      check_output("overflow_set", 16'(overflow), 16'd1);
      drain();
      check_output("overflow_sticky", 16'(overflow), 16'd1);

      // Asynchronous reset with three stored entries and overflow set.
      for (int i = 0; i < 3; i++)
         apply_stimulus(8'hC0 + 8'(i), 8'h0C, 5);
      check_output("pre_reset_count", 16'(count), 16'd3);
      do_reset();

      // Full FIFO with a pop on the capture edge accepts the capture.
      for (int i = 1; i <= 4; i++) begin
         exp_q.push_back({8'h90 + 8'(i), 8'h09});
         apply_stimulus(8'h90 + 8'(i), 8'h09, 5);
      end
      check_output("pre_simul_count", 16'(count), 16'd4);
      a_in = 8'h99; b_in = 8'h99; load = 1'b1;
      exp_q.push_back(16'h9999);
      repeat (4) step();
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      check_output("simul_count", 16'(count), 16'd4);
      check_output("simul_overflow", 16'(overflow), 16'd0);
      load = 1'b0;
      repeat (4) step();
      drain();

      // ena low blocks captures but not pops.
      exp_q.push_back(16'hA1A1);
      apply_stimulus(8'hA1, 8'hA1, 5);
      exp_q.push_back(16'hA2A2);
      apply_stimulus(8'hA2, 8'hA2, 5);
      check_output("ena_pre_count", 16'(count), 16'd2);
      ena = 1'b0;
      out_ready = 1'b1;
      apply_stimulus(8'hEE, 8'hEE, 5);
      check_output("ena_count", 16'(count), 16'd0);
      out_ready = 1'b0;
      ena = 1'b1;

      // Reset mid-qualification restarts the full qualification.
      a_in = 8'h3C; b_in = 8'hC3; load = 1'b1;
      repeat (3) step();
      do_reset();
      exp_q.push_back(16'h3CC3);
      repeat (4) step();
      check_output("requal_not_yet", 16'(count), 16'd0);
      step();
      check_output("requal_count", 16'(count), 16'd1);
      load = 1'b0;
      repeat (4) step();
      drain();

      check_output("scoreboard_empty", 16'(exp_q.size()), 16'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
